// File: rtl/inst_fifo.sv
// inst_fifo
// Dual-issue instruction queue sitting between fetch and decode. Fetch may
// push up to two {PC, instruction} pairs per cycle and decode may pop up to
// two. The head and head+1 entries are presented combinationally so decode
// sees them with zero latency. Flush discards everything in one cycle.
module inst_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        write_en1,
    input  logic        write_en2,
    input  logic [31:0] write_inst1,
    input  logic [31:0] write_inst2,
    input  logic [31:0] write_addr1,
    input  logic [31:0] write_addr2,
    input  logic        read_en1,
    input  logic        read_en2,
    output logic [31:0] read_inst1,
    output logic [31:0] read_inst2,
    output logic [31:0] read_addr1,
    output logic [31:0] read_addr2,
    output logic        empty,
    output logic        almost_empty,
    output logic        fifo_full
);

    // Pointer width wraps naturally modulo DEPTH because DEPTH is a power of
    // two; the counter needs one extra bit to represent a completely full queue.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Entry storage: PC and instruction kept in parallel arrays.
    logic [31:0] addr_mem_q [DEPTH];
    logic [31:0] inst_mem_q [DEPTH];

    logic [PW-1:0] head_q;
    logic [PW-1:0] head_d;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] tail_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;

    logic [CW-1:0] free_slots;
    logic [CW-1:0] push_req;
    logic [CW-1:0] pop_req;
    logic [CW-1:0] push_num;
    logic [CW-1:0] pop_num;

    logic          wr_slot1;
    logic          wr_slot2;

    assign head_p1    = head_q + PTR_ONE;
    assign tail_p1    = tail_q + PTR_ONE;
    assign free_slots = DEPTH_C - count_q;

    // Size the push and pop requests and clamp them to what the queue can
    // actually supply or accept. Slot 2 only counts when slot 1 is also
    // requested, so a lone second enable is ignored. Free space is measured
    // before this cycle's pops, so a pop never makes room for a same-cycle push.
    always_comb begin
        push_req = '0;
        pop_req  = '0;
        if (write_en1) begin
            push_req = write_en2 ? TWO_C : ONE_C;
        end
        if (read_en1) begin
            pop_req = read_en2 ? TWO_C : ONE_C;
        end
        push_num = (push_req > free_slots) ? free_slots : push_req;
        pop_num  = (pop_req > count_q) ? count_q : pop_req;
    end

    // Flush wins over everything; otherwise advance pointers and occupancy
    // by the clamped push/pop amounts in the same cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + pop_num[PW-1:0];
            tail_d  = tail_q + push_num[PW-1:0];
            count_d = count_q + push_num - pop_num;
        end
    end

    assign wr_slot1 = !flush && (push_num != '0);
    assign wr_slot2 = !flush && (push_num == TWO_C);

    // Pointer and occupancy registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never reset; unread slots are masked on the outputs.
    always_ff @(posedge clk) begin
        if (wr_slot1) begin
            addr_mem_q[tail_q] <= write_addr1;
            inst_mem_q[tail_q] <= write_inst1;
        end
        if (wr_slot2) begin
            addr_mem_q[tail_p1] <= write_addr2;
            inst_mem_q[tail_p1] <= write_inst2;
        end
    end

    // Zero-latency read ports; a slot with no valid entry reads as zero.
    assign read_addr1 = (count_q != '0)   ? addr_mem_q[head_q]  : 32'h0;
    assign read_inst1 = (count_q != '0)   ? inst_mem_q[head_q]  : 32'h0;
    assign read_addr2 = (count_q >= TWO_C) ? addr_mem_q[head_p1] : 32'h0;
    assign read_inst2 = (count_q >= TWO_C) ? inst_mem_q[head_p1] : 32'h0;

    // Status flags depend only on the registered occupancy.
    assign empty        = (count_q == '0);
    assign almost_empty = (count_q == ONE_C);
    assign fifo_full    = (count_q >= FULL_C);

endmodule

// File: tb/tb_inst_fifo.sv
// tb_inst_fifo
// Bench for inst_fifo: a queue-based reference model tracks the expected
// contents; a negedge process compares every output against it each cycle,
// and directed sequences pin specific literal values.
module tb_inst_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_inst1;
    logic [31:0] write_inst2;
    logic [31:0] write_addr1;
    logic [31:0] write_addr2;
    logic        read_en1;
    logic        read_en2;
    logic [31:0] read_inst1;
    logic [31:0] read_inst2;
    logic [31:0] read_addr1;
    logic [31:0] read_addr2;
    logic        empty;
    logic        almost_empty;
    logic        fifo_full;

    int          total;
    int          bad;
    bit          running;
    logic [63:0] modelQ [$];
    int          headPos;
    int          wraps;

    inst_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .write_en1    (write_en1),
        .write_en2    (write_en2),
        .write_inst1  (write_inst1),
        .write_inst2  (write_inst2),
        .write_addr1  (write_addr1),
        .write_addr2  (write_addr2),
        .read_en1     (read_en1),
        .read_en2     (read_en2),
        .read_inst1   (read_inst1),
        .read_inst2   (read_inst2),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .empty        (empty),
        .almost_empty (almost_empty),
        .fifo_full    (fifo_full)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] pcOf(input int i);
        return 32'h1000_0000 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] instOf(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one clock edge: flush clears, otherwise pop from
    // the front (bounded by contents) then append what fits in the space that
    // was free before the pop.
    task automatic modelStep(input logic f, input logic w1, input logic w2,
                             input logic r1, input logic r2,
                             input logic [31:0] a1, input logic [31:0] i1,
                             input logic [31:0] a2, input logic [31:0] i2);
        int sz;
        int nPop;
        int nPush;
        sz    = modelQ.size();
        nPop  = r1 ? ((r2 ? 2 : 1) < sz ? (r2 ? 2 : 1) : sz) : 0;
        nPush = w1 ? ((w2 ? 2 : 1) < (DEPTH - sz) ? (w2 ? 2 : 1) : (DEPTH - sz)) : 0;
        if (f) begin
            modelQ.delete();
            headPos = 0;
        end else begin
            for (int k = 0; k < nPop; k++) begin
                void'(modelQ.pop_front());
                headPos++;
                if (headPos == DEPTH) begin
                    headPos = 0;
                    wraps++;
                end
            end
            if (nPush >= 1) modelQ.push_back({a1, i1});
            if (nPush == 2) modelQ.push_back({a2, i2});
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model,
    // and return just after the edge so callers can check literal values.
    task automatic applyStimulus(input logic f, input logic w1, input logic w2,
                                 input logic r1, input logic r2,
                                 input logic [31:0] a1, input logic [31:0] i1,
                                 input logic [31:0] a2, input logic [31:0] i2);
        flush       = f;
        write_en1   = w1;
        write_en2   = w2;
        read_en1    = r1;
        read_en2    = r2;
        write_addr1 = a1;
        write_inst1 = i1;
        write_addr2 = a2;
        write_inst2 = i2;
        @(posedge clk);
        modelStep(f, w1, w2, r1, r2, a1, i1, a2, i2);
        #1;
    endtask

    task automatic pushPair(input int i);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pcOf(i), instOf(i), pcOf(i + 1), instOf(i + 1));
    endtask

    task automatic pushOne(input int i);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pcOf(i), instOf(i), 32'h0, 32'h0);
    endtask

    task automatic popTwo();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    // Asserts reset between clock edges, holds it for two negedges, and
    // releases it just after a negedge.
    task automatic applyReset(input bit checkState);
        #2;
        rst_n     = 1'b0;
        flush     = 1'b0;
        write_en1 = 1'b0;
        write_en2 = 1'b0;
        read_en1  = 1'b0;
        read_en2  = 1'b0;
        modelQ.delete();
        headPos = 0;
        @(negedge clk);
        if (checkState) begin
            checkOutput("rst_empty",        32'(empty),        32'd1);
            checkOutput("rst_almost_empty", 32'(almost_empty), 32'd0);
            checkOutput("rst_fifo_full",    32'(fifo_full),    32'd0);
            checkOutput("rst_read_addr1",   read_addr1,        32'h0);
            checkOutput("rst_read_inst2",   read_inst2,        32'h0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Every cycle, compare all outputs against the model's view.
    always @(negedge clk) begin : compare
        int          sz;
        logic [63:0] h1;
        logic [63:0] h2;
        if (running) begin
            sz = modelQ.size();
            h1 = (sz > 0) ? modelQ[0] : 64'h0;
            h2 = (sz > 1) ? modelQ[1] : 64'h0;
            checkOutput("cmp_read_addr1",   read_addr1,        h1[63:32]);
            checkOutput("cmp_read_inst1",   read_inst1,        h1[31:0]);
            checkOutput("cmp_read_addr2",   read_addr2,        h2[63:32]);
            checkOutput("cmp_read_inst2",   read_inst2,        h2[31:0]);
            checkOutput("cmp_empty",        32'(empty),        32'(sz == 0));
            checkOutput("cmp_almost_empty", 32'(almost_empty), 32'(sz == 1));
            checkOutput("cmp_fifo_full",    32'(fifo_full),    32'(sz >= DEPTH - 1));
        end
    end

    initial begin
        total       = 0;
        bad         = 0;
        headPos     = 0;
        wraps       = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        write_en1   = 1'b0;
        write_en2   = 1'b0;
        read_en1    = 1'b0;
        read_en2    = 1'b0;
        write_addr1 = 32'h0;
        write_inst1 = 32'h0;
        write_addr2 = 32'h0;
        write_inst2 = 32'h0;
        running     = 1'b1;

        // Reset state, then a single dual push at the boot vector.
        applyReset(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                      32'hBFC0_0000, 32'h2408_0001, 32'hBFC0_0004, 32'h2409_0002);
        checkOutput("boot_read_addr1",   read_addr1,        32'hBFC0_0000);
        checkOutput("boot_read_inst1",   read_inst1,        32'h2408_0001);
        checkOutput("boot_read_addr2",   read_addr2,        32'hBFC0_0004);
        checkOutput("boot_read_inst2",   read_inst2,        32'h2409_0002);
        checkOutput("boot_empty",        32'(empty),        32'd0);
        checkOutput("boot_almost_empty", 32'(almost_empty), 32'd0);

        // Fill with pairs, fifth pair must be dropped entirely.
        applyReset(1'b0);
        for (int c = 0; c < 5; c++) begin
            pushPair(2 * c);
            if (c == 2) checkOutput("fill3_fifo_full", 32'(fifo_full), 32'd0);
            if (c == 3) checkOutput("fill4_fifo_full", 32'(fifo_full), 32'd1);
        end
        checkOutput("fill5_read_addr1", read_addr1, 32'h1000_0000);
        checkOutput("fill5_read_addr2", read_addr2, 32'h1000_0004);
        popTwo();
        popTwo();
        popTwo();
        checkOutput("drain_read_addr1", read_addr1, 32'h1000_0018);
        checkOutput("drain_read_inst1", read_inst1, 32'hA000_0006);
        checkOutput("drain_read_addr2", read_addr2, 32'h1000_001C);
        popTwo();
        checkOutput("drain_empty", 32'(empty), 32'd1);

        // One free slot with both enables: slot 2 is discarded.
        applyReset(1'b0);
        pushPair(0);
        pushPair(2);
        pushPair(4);
        pushOne(6);
        checkOutput("occ7_fifo_full", 32'(fifo_full), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pcOf(7), instOf(7), 32'hDEAD_0000, 32'hDEAD_BEEF);
        popTwo();
        popTwo();
        popTwo();
        checkOutput("last1_read_addr1", read_addr1, 32'h1000_0018);
        checkOutput("last1_read_addr2", read_addr2, 32'h1000_001C);
        checkOutput("last1_read_inst2", read_inst2, 32'hA000_0007);
        popTwo();
        checkOutput("last1_empty", 32'(empty), 32'd1);

        // Occupancy 1 with a dual pop: one entry leaves, no underflow.
        applyReset(1'b0);
        pushOne(0);
        checkOutput("occ1_almost_empty", 32'(almost_empty), 32'd1);
        popTwo();
        checkOutput("underflow_empty",      32'(empty), 32'd1);
        checkOutput("underflow_read_addr1", read_addr1, 32'h0);
        pushPair(1);
        checkOutput("after_uf_read_addr1", read_addr1, 32'h1000_0004);
        checkOutput("after_uf_read_addr2", read_addr2, 32'h1000_0008);

        // Flush beats a same-cycle push and pop.
        applyReset(1'b0);
        pushPair(0);
        pushPair(2);
        pushOne(4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, pcOf(5), instOf(5), 32'h0, 32'h0);
        checkOutput("flush_empty",      32'(empty),     32'd1);
        checkOutput("flush_fifo_full",  32'(fifo_full), 32'd0);
        checkOutput("flush_read_addr1", read_addr1,     32'h0);
        checkOutput("flush_read_inst1", read_inst1,     32'h0);
        pushOne(9);
        checkOutput("postflush_almost_empty", 32'(almost_empty), 32'd1);
        checkOutput("postflush_read_addr1",   read_addr1,        32'h1000_0024);
        checkOutput("postflush_read_addr2",   read_addr2,        32'h0);

        // Random traffic with occasional flush and one mid-burst reset;
        // read pressure alternates every 100 cycles to visit full and empty.
        applyReset(1'b0);
        for (int n = 0; n < 1000; n++) begin
            logic f;
            logic w1;
            logic w2;
            logic r1;
            logic r2;
            if (n == 500) applyReset(1'b0);
            f  = ($urandom_range(0, 49) == 0);
            w1 = ($urandom_range(0, 3) != 0);
            w2 = 1'($urandom_range(0, 1));
            r1 = (((n / 100) % 2) == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) != 0);
            r2 = 1'($urandom_range(0, 1));
            applyStimulus(f, w1, w2, r1, r2,
                          32'h2000_0000 + 32'(8 * n), $urandom(),
                          32'h2000_0004 + 32'(8 * n), $urandom());
        end
        $display("[TB] head pointer wraps seen by model: %0d", wraps);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
